// File: rtl/dco_coarse_tuner_if.sv
`timescale 1ps/1ps
// Control/status bundle of the DCO coarse tuner: reference, target and start in,
// coarse code and acquisition status out.
interface dco_coarse_tuner_if #(
  parameter int CODE_W = 7,
  parameter int CNT_W  = 12
);
  logic              ref_in;
  logic [7:0]        fcw;
  logic              start;
  logic [CODE_W-1:0] coarse;
  logic              search_done;
  logic              lock;
  logic [CNT_W-1:0]  meas_cnt;

  modport master (
    output ref_in, fcw, start,
    input  coarse, search_done, lock, meas_cnt
  );

  modport slave (
    input  ref_in, fcw, start,
    output coarse, search_done, lock, meas_cnt
  );
endinterface

// File: rtl/dco_coarse_tuner.sv
`timescale 1ps/1ps
// DCO coarse-code acquisition: counts DCO cycles over WIN reference periods, runs a
// binary search on the code, then tracks +/-1 inside a dead-band and reports lock.
module dco_coarse_tuner #(
  parameter int CODE_W   = 7,
  parameter int CNT_W    = 12,
  parameter int WIN      = 4,
  parameter int DB       = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dco_coarse_tuner_if.slave io_bus
);
  localparam int IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int EDGE_W = $clog2(WIN + 1);
  localparam int LCK_W  = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_MEAS, S_EVAL} state_t;

  state_t              r_state;
  logic [2:0]          r_ref_sync;
  logic [CODE_W-1:0]   r_coarse;
  logic [IDX_W-1:0]    r_bit_idx;
  logic                r_phase_trk;
  logic                r_search_done;
  logic                r_lock;
  logic [CNT_W-1:0]    r_meas_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [EDGE_W-1:0]   r_edge_cnt;
  logic [LCK_W-1:0]    r_lock_cnt;
  logic [CNT_W-1:0]    r_target;

  state_t              w_state_nxt;
  logic [CODE_W-1:0]   w_coarse_nxt;
  logic [CODE_W-1:0]   w_trial;
  logic [IDX_W-1:0]    w_bit_nxt;
  logic                w_phase_nxt;
  logic                w_done_nxt;
  logic                w_lock_nxt;
  logic [CNT_W-1:0]    w_meas_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [EDGE_W-1:0]   w_edge_nxt;
  logic [LCK_W-1:0]    w_lock_cnt_nxt;
  logic [CNT_W-1:0]    w_target_nxt;
  logic                w_ref_rise;
  logic [CNT_W:0]      w_tgt_hi;
  logic [CNT_W:0]      w_tgt_lo;
  logic [CNT_W:0]      w_meas_ext;

  // Two-flop synchroniser plus one delay stage for rising-edge detection of REF_IN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ref_sync <= 3'b000;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], io_bus.ref_in};
    end
  end

  assign w_ref_rise = r_ref_sync[1] & ~r_ref_sync[2];

  // Band edges carry one extra bit so target+DB cannot wrap; the low edge floors at 0
  assign w_meas_ext = {1'b0, r_meas_cnt};
  assign w_tgt_hi   = {1'b0, r_target} + (CNT_W+1)'(DB);
  assign w_tgt_lo   = (r_target >= CNT_W'(DB)) ? ({1'b0, r_target} - (CNT_W+1)'(DB))
                                               : {(CNT_W+1){1'b0}};

  // Next-state and datapath decisions; START overrides every state
  always_comb begin
    w_state_nxt    = r_state;
    w_coarse_nxt   = r_coarse;
    w_trial        = r_coarse;
    w_bit_nxt      = r_bit_idx;
    w_phase_nxt    = r_phase_trk;
    w_done_nxt     = r_search_done;
    w_lock_nxt     = r_lock;
    w_meas_nxt     = r_meas_cnt;
    w_cnt_nxt      = r_cnt;
    w_edge_nxt     = r_edge_cnt;
    w_lock_cnt_nxt = r_lock_cnt;
    w_target_nxt   = r_target;
    if (io_bus.start) begin
      w_coarse_nxt   = {1'b1, {(CODE_W-1){1'b0}}};
      w_bit_nxt      = IDX_W'(CODE_W - 1);
      w_phase_nxt    = 1'b0;
      w_done_nxt     = 1'b0;
      w_lock_nxt     = 1'b0;
      w_lock_cnt_nxt = {LCK_W{1'b0}};
      w_cnt_nxt      = {CNT_W{1'b0}};
      w_edge_nxt     = {EDGE_W{1'b0}};
      w_target_nxt   = {{(CNT_W-8){1'b0}}, io_bus.fcw} * CNT_W'(WIN);
      w_state_nxt    = S_ALIGN;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_ALIGN: begin
          if (w_ref_rise) begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_edge_nxt  = {EDGE_W{1'b0}};
            w_state_nxt = S_MEAS;
          end else begin
            w_state_nxt = S_ALIGN;
          end
        end
        S_MEAS: begin
          // Saturate rather than wrap so a lost reference cannot fake a slow DCO
          w_cnt_nxt = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1));
          if (w_ref_rise) begin
            w_edge_nxt = r_edge_cnt + EDGE_W'(1);
            if (r_edge_cnt == EDGE_W'(WIN - 1)) begin
              w_meas_nxt  = w_cnt_nxt;
              w_state_nxt = S_EVAL;
            end else begin
              w_state_nxt = S_MEAS;
            end
          end else begin
            w_state_nxt = S_MEAS;
          end
        end
        S_EVAL: begin
          w_state_nxt = S_ALIGN;
          if (!r_phase_trk) begin
            if (r_meas_cnt > r_target) begin
              w_trial[r_bit_idx] = 1'b0;
            end else begin
              w_trial[r_bit_idx] = r_coarse[r_bit_idx];
            end
            if (r_bit_idx == IDX_W'(0)) begin
              w_done_nxt     = 1'b1;
              w_phase_nxt    = 1'b1;
              w_lock_cnt_nxt = {LCK_W{1'b0}};
            end else begin
              w_bit_nxt          = r_bit_idx - IDX_W'(1);
              w_trial[w_bit_nxt] = 1'b1;
            end
            w_coarse_nxt = w_trial;
          end else begin
            if (w_meas_ext > w_tgt_hi) begin
              w_coarse_nxt   = (r_coarse == {CODE_W{1'b0}}) ? r_coarse : (r_coarse - CODE_W'(1));
              w_lock_cnt_nxt = {LCK_W{1'b0}};
              w_lock_nxt     = 1'b0;
            end else if (w_meas_ext < w_tgt_lo) begin
              w_coarse_nxt   = (&r_coarse) ? r_coarse : (r_coarse + CODE_W'(1));
              w_lock_cnt_nxt = {LCK_W{1'b0}};
              w_lock_nxt     = 1'b0;
            end else begin
              w_lock_cnt_nxt = (r_lock_cnt == LCK_W'(LOCK_CNT)) ? r_lock_cnt
                                                                 : (r_lock_cnt + LCK_W'(1));
              w_lock_nxt     = (w_lock_cnt_nxt == LCK_W'(LOCK_CNT));
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_coarse      <= {CODE_W{1'b0}};
      r_bit_idx     <= {IDX_W{1'b0}};
      r_phase_trk   <= 1'b0;
      r_search_done <= 1'b0;
      r_lock        <= 1'b0;
      r_meas_cnt    <= {CNT_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_edge_cnt    <= {EDGE_W{1'b0}};
      r_lock_cnt    <= {LCK_W{1'b0}};
      r_target      <= {CNT_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_coarse      <= w_coarse_nxt;
      r_bit_idx     <= w_bit_nxt;
      r_phase_trk   <= w_phase_nxt;
      r_search_done <= w_done_nxt;
      r_lock        <= w_lock_nxt;
      r_meas_cnt    <= w_meas_nxt;
      r_cnt         <= w_cnt_nxt;
      r_edge_cnt    <= w_edge_nxt;
      r_lock_cnt    <= w_lock_cnt_nxt;
      r_target      <= w_target_nxt;
    end
  end

  assign io_bus.coarse      = r_coarse;
  assign io_bus.search_done = r_search_done;
  assign io_bus.lock        = r_lock;
  assign io_bus.meas_cnt    = r_meas_cnt;
endmodule
